// File: rtl/icache_controller_if.sv
// ---------------------------------------------------------------------------
// icache_controller_if
// Bundles the CPU fetch port and the instruction-memory block port of the
// instruction cache.
//   CPU side : read, address (in); readdata, busywait (out of cache)
//   Mem side : mem_read, mem_address (out of cache); mem_readdata,
//              mem_busywait (in)
// modport slave  : the cache controller
// modport master : the environment (CPU fetch stage + instruction memory)
// ---------------------------------------------------------------------------
interface icache_controller_if;
  logic         read;
  logic [31:0]  address;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, address, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_address
  );

  modport master (
    output read, address, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_controller.sv
// ---------------------------------------------------------------------------
// icache_controller
// Direct-mapped, read-only instruction cache with a single-block refill
// engine. Hits are served combinationally; a miss stalls the CPU, fetches
// one 128-bit block, installs it and then serves the fetch.
//   clock : system clock (posedge)
//   reset : synchronous, active-high
//   bus   : icache_controller_if.slave (CPU fetch port + memory block port)
// ---------------------------------------------------------------------------
module icache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  icache_controller_if.slave   bus
);
  localparam int TAG_W = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t             r_state, w_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [127:0]       r_data [LINES];
  logic [27:0]        r_miss_addr;
  logic               r_guard;   // first MEM_READ cycle: mem_busywait not yet meaningful

  logic [INDEX_BITS-1:0] w_index, w_miss_index;
  logic [TAG_W-1:0]      w_tag, w_miss_tag;
  logic [1:0]            w_word;
  logic                  w_hit, w_fill;
  logic                  w_busywait, w_mem_read;
  logic [27:0]           w_mem_address;
  logic                  w_unused;

  assign w_word       = bus.address[3:2];
  assign w_index      = bus.address[3+INDEX_BITS:4];
  assign w_tag        = bus.address[31:4+INDEX_BITS];
  assign w_miss_index = r_miss_addr[INDEX_BITS-1:0];
  assign w_miss_tag   = r_miss_addr[27:INDEX_BITS];
  assign w_unused     = &{1'b0, bus.address[1:0]};

  assign w_hit    = bus.read && r_valid[w_index] && (r_tag[w_index] == w_tag);
  // Block returns on the first post-guard cycle with memory no longer busy.
  assign w_fill   = (r_state == MEM_READ) && !r_guard && !bus.mem_busywait;

  assign bus.readdata    = r_data[w_index][{w_word, 5'b0} +: 32];
  assign bus.busywait    = w_busywait;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_address = w_mem_address;

  always_comb begin
    w_next        = r_state;
    w_busywait    = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_address = 28'd0;
    case (r_state)
      IDLE: begin
        w_busywait = bus.read && !w_hit;
        if (w_busywait) w_next = MEM_READ;
      end
      MEM_READ: begin
        w_busywait    = 1'b1;
        w_mem_read    = 1'b1;
        w_mem_address = r_miss_addr;
        if (w_fill) w_next = UPDATE;
      end
      UPDATE: begin
        // Line already installed; this cycle lets the hit logic settle.
        w_busywait = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_miss_addr <= 28'd0;
      r_guard     <= 1'b1;
    end else begin
      r_state <= w_next;
      r_guard <= (r_state != MEM_READ);
      if (r_state == IDLE && w_next == MEM_READ)
        r_miss_addr <= {w_tag, w_index};
      if (w_fill)
        r_valid[w_miss_index] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge clock) begin
    if (w_fill && !reset) begin
      r_data[w_miss_index] <= bus.mem_readdata;
      r_tag[w_miss_index]  <= w_miss_tag;
    end
  end
endmodule

// File: tb/tb_icache_controller.sv
// ---------------------------------------------------------------------------
// tb_icache_controller
// Directed bench: CPU fetch driver plus a behavioural instruction memory
// that holds mem_busywait high for MEM_BUSY cycles of each request.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
// ---------------------------------------------------------------------------
module tb_icache_controller;
  localparam int MEM_BUSY = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   mcnt = 0;

  icache_controller_if bus();

  icache_controller #(.INDEX_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Word w of the block at block address ba.
  function automatic logic [31:0] wrd(input logic [27:0] ba, input int w);
    return 32'h00A00083 + (w << 4) + ({4'b0, ba} << 12);
  endfunction

  function automatic logic [127:0] blk(input logic [27:0] ba);
    return {wrd(ba, 3), wrd(ba, 2), wrd(ba, 1), wrd(ba, 0)};
  endfunction

  // Memory: busy in the cycle mem_read rises and MEM_BUSY-1 more, then data.
  always @(negedge clock) begin
    if (bus.mem_read) begin
      bus.mem_busywait = (mcnt < MEM_BUSY);
      bus.mem_readdata = blk(bus.mem_address);
      mcnt++;
    end else begin
      bus.mem_busywait = 1'b0;
      mcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Fetch addr; count stalled cycles, note memory addresses, check the word.
  task automatic fetch(input string tag, input logic [31:0] a, input int exp_busy,
                       input logic [27:0] exp_ma);
    int nb = 0;
    logic [27:0] ma = 28'd0;
    logic ma_bad = 1'b0;
    logic done = 1'b0;
    @(posedge clock); #1;
    bus.address = a;
    bus.read    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!bus.busywait) begin done = 1'b1; break; end
      nb++;
      if (bus.mem_read) begin
        ma = bus.mem_address;
        if (bus.mem_address != exp_ma) ma_bad = 1'b1;
      end else if (bus.mem_address != 28'd0) ma_bad = 1'b1;
      @(posedge clock); #1;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, nb, exp_busy);
    if (exp_busy > 0) chk({tag, "_maddr"}, {4'd0, ma} | {31'd0, ma_bad}, {4'd0, exp_ma});
    chk({tag, "_mrd"}, {31'd0, bus.mem_read}, 32'd0);
    chk({tag, "_data"}, bus.readdata, wrd(a[31:4], int'(a[3:2])));
  endtask

  initial begin
    logic saw1, saw2, bad_order;
    int nb;
    bus.read = 1'b1;
    bus.address = 32'h4;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;

    // Reset: all lines invalid so busywait follows read; memory idle.
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_busy", {31'd0, bus.busywait}, 32'd1);
    chk("rst_mrd", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_maddr", {4'd0, bus.mem_address}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.read = 1'b0;

    // Cold miss: 1 detect + 1 guard + 3 busy + 1 update.
    fetch("cold", 32'h4, 6, 28'h0);
    chk("cold_word1", bus.readdata, 32'h00A00093);
    fetch("hit8", 32'h8, 0, 28'h0);
    fetch("hitC", 32'hC, 0, 28'h0);

    // Conflict on index 0.
    fetch("hit0", 32'h0, 0, 28'h0);
    fetch("evict80", 32'h80, 6, 28'h8);
    chk("evict80_word", bus.readdata, 32'h00A08083);
    fetch("evict0", 32'h0, 6, 28'h0);

    // Address change in MEM_READ: refill of 0x1 completes, then 0x2 misses.
    @(posedge clock); #1;
    bus.address = 32'h10;
    bus.read = 1'b1;
    saw1 = 1'b0; saw2 = 1'b0; bad_order = 1'b0; nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!bus.busywait) break;
      nb++;
      if (bus.mem_read && bus.mem_address == 28'h1) begin saw1 = 1'b1; if (saw2) bad_order = 1'b1; end
      if (bus.mem_read && bus.mem_address == 28'h2) saw2 = 1'b1;
      @(posedge clock); #1;
      if (i == 1) bus.address = 32'h20;
    end
    chk("chg_busy", nb, 12);
    chk("chg_seq", {29'd0, saw1, saw2, bad_order}, 32'b110);
    chk("chg_data", bus.readdata, 32'h00A02083);
    fetch("chg_line1", 32'h14, 0, 28'h0);

    // Reset in the 2nd MEM_READ cycle.
    fetch("pre_rst", 32'h4, 0, 28'h0);
    @(posedge clock); #1;
    bus.address = 32'h30;
    @(posedge clock); #1;   // MEM_READ guard
    @(posedge clock); #1;   // MEM_READ 2nd cycle
    reset = 1'b1;
    @(negedge clock);
    chk("mid_mrd", {31'd0, bus.mem_read}, 32'd1);
    chk("mid_maddr", {4'd0, bus.mem_address}, 32'h3);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.read = 1'b0;
    @(negedge clock);
    chk("post_rst_mrd", {31'd0, bus.mem_read}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busywait}, 32'd0);
    chk("post_rst_maddr", {4'd0, bus.mem_address}, 32'd0);
    fetch("remiss4", 32'h4, 6, 28'h0);

    // Idle: read low, wandering address.
    @(posedge clock); #1;
    bus.read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.address = 32'h1000 * i + 32'h44;
      @(negedge clock);
      chk("idle_busy", {31'd0, bus.busywait}, 32'd0);
      chk("idle_mrd", {31'd0, bus.mem_read}, 32'd0);
      @(posedge clock); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache and refill controller between the CPU fetch stage and the 128-bit-block instruction memory.
- Serves 32-bit instructions on hit in the same cycle.
- On a miss, stalls the CPU with busywait, fetches one 16-byte block from instruction memory, installs it and then serves the fetch.
- Sole master of the instruction memory read port.

Parameters:
- INDEX_BITS, 3, log2 of number of cache lines (default 8 lines x 128 bits); tag width = 28 - INDEX_BITS.

Ports:
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- read  input  1  CPU fetch request, level, held high while CPU wants an instruction
- address  input  32  CPU PC; [1:0] ignored, [3:2] word select, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag
- readdata  output  32  selected instruction word
- busywait  output  1  CPU stall; high while request cannot be served this cycle
- mem_read  output  1  instruction memory read request, level
- mem_address  output  28  block address to instruction memory, {tag,index}
- mem_readdata  input  128  block from memory; byte k of block at bits [8k+7:8k]
- mem_busywait  input  1  memory busy; memory raises it in the cycle mem_read rises, lowers it when mem_readdata is valid

Behaviour:
- Storage per line: valid bit, tag, 128-bit data.
- Hit (combinational): read && valid[index] && tag[index]==address tag.
- readdata = data[index][32*w+31:32*w], with w = address[3:2]. Combinational from the current address and array.
- readdata is don't-care on a miss; the bench checks it only when busywait==0.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = read && !hit.
  - mem_read = 0.
  - On miss at posedge: latch {tag,index} into miss_addr and go to MEM_READ.
  - read==0 means busywait=0 and no transition.
- MEM_READ:
  - mem_read = 1, mem_address = miss_addr, busywait = 1.
  - First cycle in the state is a guard cycle: mem_busywait is not sampled.
  - From the second cycle on, at a posedge with mem_busywait==0, capture mem_readdata and go to UPDATE.
  - No timeout; the state is held indefinitely while mem_busywait is high.
- UPDATE:
  - On entry: data[miss index] = captured block, tag = miss tag, valid = 1.
  - mem_read = 0, busywait = 1.
  - Next posedge goes to IDLE unconditionally.
  - The hit is then re-evaluated against the current address, so the refilled line serves the fetch on the first IDLE cycle.
- Miss-to-instruction latency: 1 (IDLE detect) + 1 guard + N (memory busy cycles) + 1 (UPDATE) cycles before busywait falls.
- Address change during a refill:
  - The refill completes for miss_addr regardless.
  - On return to IDLE, the new address is evaluated normally (hit or new miss).
  - read dropping mid-refill does not abort the refill.
- Replacement: the refill overwrites the line unconditionally, whether the old line is valid or invalid. No write path or dirty state (read-only cache).
- mem_address holds miss_addr in MEM_READ; it is 0 in IDLE and UPDATE.
- Reset (synchronous, any state, including mid-refill):
  - All valid bits cleared, FSM to IDLE, miss_addr = 0.
  - mem_read = 0, busywait low in the following cycle unless read is high (then it re-misses).
  - Tag and data arrays are not cleared.
- Reset outputs: readdata = don't-care (array content), busywait = read (all lines invalid), mem_read = 0, mem_address = 0.
- Index wrap: addresses differing only in tag map to the same line and evict each other.

Test Plan:
- Cold miss:
  - Stimulus: reset, then read=1, address=0x00000004, memory with 3 busy cycles returning a block whose word1 = 0x00A00093.
  - Required: busywait=1 for 1+1+3+1 = 6 cycles; mem_read=1 with mem_address=0x0000000 in MEM_READ only; then busywait=0 and readdata=0x00A00093.
- Same-block hit:
  - Stimulus: after the cold miss, address=0x00000008, then 0x0000000C.
  - Required: busywait=0 each cycle, mem_read stays 0, readdata = block words 2 and 3.
- Conflict eviction:
  - Stimulus: fill line 0 from 0x00000000, then fetch 0x00000080 (same index 0, tag 1), then 0x00000000 again.
  - Required: the 2nd and 3rd fetches both miss, with mem_address 0x0000008 and then 0x0000000.
- Address change mid-refill:
  - Stimulus: miss on 0x00000010, change address to 0x00000020 during MEM_READ.
  - Required: mem_address stays 0x0000001; line 1 is valid afterwards; a second miss follows with mem_address=0x0000002.
- Reset mid-refill:
  - Stimulus: assert reset in the 2nd MEM_READ cycle.
  - Required: next cycle mem_read=0, state IDLE; a previously cached 0x00000004 now misses.
- Idle:
  - Stimulus: read=0 with any address.
  - Required: busywait=0, mem_read=0 for 10 cycles.
